mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported, variable-latency unified memory between the pipeline's instruction fetch (IF) and data access (MEM) stages. It sits between the CPU pipeline and the memory and serialises the two requesters, data first. It holds a global `stall_o` that freezes PC, IFID, IDEX, EXMEM and MEMWB until every access needed in the current pipeline cycle has completed. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/sat_counter.sv | 33 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Arbiter state encoding, bus width defaults, counter limit.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and sync reset.
// Ports: clk_i, rst_i, en_i in; cnt_o out (W bits).
module sat_counter #(
  parameter int          W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between IF and MEM,
// data first, freezing the pipeline via stall_o.
// Ports: if_* / dm_* from the pipeline, mem_* to the
// memory, if_inst_o / dm_rdata_o results, stall_o,
// stall_cnt_o (saturating count of stalled cycles).
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       stall_cnt_o
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;

  logic need_dm;
  logic need_if;
  logic stall;

  // Done flags remember which accesses already
  // finished during the current frozen cycle.
  assign need_dm = (dm_read_i | dm_write_i) & ~dm_done_q;
  assign need_if = if_req_i & ~if_done_q;
  assign stall   = need_dm | need_if | (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_inst_d   = if_inst_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = if_done_q;
    dm_done_d   = dm_done_q;

    // Pipeline advances: next cycle has fresh needs.
    if (!stall) begin
      if_done_d = 1'b0;
      dm_done_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Data wins: the MEM-stage op is older.
        if (need_dm) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
        end else if (need_if) begin
          state_d    = INST;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
        end
      end
      DATA: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_done_d = 1'b1;
          // Read+write together is treated as a write,
          // so only a pure read captures data.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      INST: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if_done_d = 1'b1;
          if_inst_d = mem_rdata_i;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_inst_q   <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_inst_q   <= if_inst_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  sat_counter #(
    .W   (32),
    .MAX (STALL_CNT_MAX)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall),
    .cnt_o (stall_cnt_o)
  );

  assign stall_o     = stall;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_inst_o   = if_inst_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table with
// a small memory responder, plus reset/saturation cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] if_inst_o;
  logic [31:0] dm_rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] stall_cnt_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .dm_read_i   (dm_read_i),
    .dm_write_i  (dm_write_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .if_inst_o   (if_inst_o),
    .dm_rdata_o  (dm_rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        rd;
    logic        wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          lat0;
    int          lat1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          exp_stall;
    int          exp_nreq;
    logic [31:0] exp_a0;
    logic        exp_we0;
    logic [31:0] exp_wd0;
    logic [31:0] exp_a1;
    logic [31:0] exp_inst;
    logic [31:0] exp_drd;
  } vec_t;

  vec_t v[6];
  vec_t sv;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_read_i   = 1'b0;
    dm_write_i  = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
  endtask

  // Applies one vector, answers requests with the
  // vector's latencies and checks the outcome.
  task automatic run_vec(input vec_t x,
                         input int id,
                         input bit cnt_delta);
    logic [31:0] a_log[2];
    logic [31:0] wd_log[2];
    logic        we_log[2];
    logic [31:0] cnt0;
    int          nreq;
    int          age;
    int          nst;
    int          lat;
    bit          inflight;
    bit          done;
    bit          held;
    string       tag;
    tag = $sformatf("v%0d", id);
    for (int i = 0; i < 2; i++) begin
      a_log[i]  = 32'hFFFF_FFFF;
      wd_log[i] = 32'hFFFF_FFFF;
      we_log[i] = 1'b1;
    end
    cnt0       = stall_cnt_o;
    if_req_i   = x.if_req;
    if_addr_i  = x.if_addr;
    dm_read_i  = x.rd;
    dm_write_i = x.wr;
    dm_addr_i  = x.dm_addr;
    dm_wdata_i = x.dm_wdata;
    #1;
    nreq = 0; age = 0; nst = 0;
    inflight = 0; done = 0; held = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'hBAD0_BAD0;
      if (mem_req_o) begin
        if (!inflight) begin
          inflight = 1;
          age      = 1;
          if (nreq < 2) begin
            a_log[nreq]  = mem_addr_o;
            we_log[nreq] = mem_we_o;
            wd_log[nreq] = mem_wdata_o;
          end
          nreq++;
        end else begin
          age++;
          if (nreq <= 2 &&
              (mem_addr_o  !== a_log[nreq-1] ||
               mem_we_o    !== we_log[nreq-1] ||
               mem_wdata_o !== wd_log[nreq-1]))
            held = 0;
        end
        lat = (nreq == 1) ? x.lat0 : x.lat1;
        if (age == lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = (nreq == 1) ? x.rd0 : x.rd1;
        end
      end else begin
        inflight = 0;
      end
      if (stall_o) nst++;
      else done = 1;
      tick();
    end
    idle_inputs();
    #1;
    chk({tag, " finished"}, {31'd0, done}, 32'd1);
    chk({tag, " stall_cycles"}, nst, x.exp_stall);
    chk({tag, " nreq"}, nreq, x.exp_nreq);
    chk({tag, " addr0"}, a_log[0], x.exp_a0);
    chk({tag, " we0"}, {31'd0, we_log[0]},
        {31'd0, x.exp_we0});
    chk({tag, " wdata0"}, wd_log[0], x.exp_wd0);
    if (x.exp_nreq == 2) begin
      chk({tag, " addr1"}, a_log[1], x.exp_a1);
      chk({tag, " we1"}, {31'd0, we_log[1]}, 32'd0);
    end
    chk({tag, " held"}, {31'd0, held}, 32'd1);
    chk({tag, " if_inst"}, if_inst_o, x.exp_inst);
    chk({tag, " dm_rdata"}, dm_rdata_o, x.exp_drd);
    chk({tag, " mem_req_low"}, {31'd0, mem_req_o}, 32'd0);
    if (cnt_delta)
      chk({tag, " stall_cnt_delta"},
          stall_cnt_o - cnt0, x.exp_stall);
  endtask

  initial begin
    v[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0,
             2, 1, 32'h8C02_0004, 32'h0,
             3, 1, 32'h40, 1'b0, 32'h0, 32'h0,
             32'h8C02_0004, 32'h0};
    v[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,
             1, 1, 32'hDEAD_BEEF, 32'h0000_0013,
             4, 2, 32'h100, 1'b0, 32'h0, 32'h44,
             32'h0000_0013, 32'hDEAD_BEEF};
    v[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200,
             32'h1234_5678, 5, 1, 32'hFFFF_0000, 32'h0,
             6, 1, 32'h200, 1'b1, 32'h1234_5678, 32'h0,
             32'h0000_0013, 32'hDEAD_BEEF};
    v[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0,
             3, 1, 32'hA5A5_A5A5, 32'h0,
             4, 1, 32'h300, 1'b0, 32'h0, 32'h0,
             32'h0000_0013, 32'hA5A5_A5A5};
    v[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h400,
             32'hCAFE_F00D, 1, 1, 32'h5555_5555, 32'h0,
             2, 1, 32'h400, 1'b1, 32'hCAFE_F00D, 32'h0,
             32'h0000_0013, 32'hA5A5_A5A5};
    v[5] = '{1'b1, 32'h48, 1'b0, 1'b1, 32'h500, 32'h1,
             2, 3, 32'h0BAD_F00D, 32'h1111_1111,
             7, 2, 32'h500, 1'b1, 32'h1, 32'h48,
             32'h1111_1111, 32'hA5A5_A5A5};
    sv   = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0,
             2, 1, 32'h2222_2222, 32'h0,
             3, 1, 32'h80, 1'b0, 32'h0, 32'h0,
             32'h2222_2222, 32'h0};

    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst mem_addr", mem_addr_o, 32'd0);
    chk("rst mem_wdata", mem_wdata_o, 32'd0);
    chk("rst if_inst", if_inst_o, 32'd0);
    chk("rst dm_rdata", dm_rdata_o, 32'd0);
    chk("rst stall_cnt", stall_cnt_o, 32'd0);

    for (int i = 0; i < 10; i++) begin
      chk("idle stall", {31'd0, stall_o}, 32'd0);
      chk("idle mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("idle stall_cnt", stall_cnt_o, 32'd0);
      tick();
    end

    for (int n = 0; n < 6; n++) begin
      run_vec(v[n], n, 1'b1);
      tick();
    end
    chk("cnt total", stall_cnt_o, 32'd26);

    // Reset lands in cycle 2 of a 4-cycle load.
    dm_read_i = 1'b1;
    dm_addr_i = 32'h600;
    tick();
    chk("rstmid req_issued", {31'd0, mem_req_o}, 32'd1);
    tick();
    rst_i     = 1'b1;
    dm_read_i = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rstmid mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rstmid stall", {31'd0, stall_o}, 32'd0);
    chk("rstmid stall_cnt", stall_cnt_o, 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("lateack mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("lateack stall", {31'd0, stall_o}, 32'd0);
    chk("lateack dm_rdata", dm_rdata_o, 32'd0);
    chk("lateack if_inst", if_inst_o, 32'd0);
    chk("lateack stall_cnt", stall_cnt_o, 32'd0);

    // Preload the stall counter just below its limit.
    @(negedge clk);
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall_cnt.cnt_q;
    #1;
    chk("sat preload", stall_cnt_o, 32'hFFFF_FFFD);
    run_vec(sv, 9, 1'b0);
    chk("sat stall_cnt", stall_cnt_o, 32'hFFFF_FFFF);
    tick();
    chk("sat hold", stall_cnt_o, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
